dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width.
REQ-002 Parameter: DATA_W, default 32, word width; fixed at 32, four byte lanes.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 n_reset  input  1  reset; synchronous, active-low.
REQ-005 valid_i  input  1  core presents a memory operation this cycle.
REQ-006 is_load_i  input  1  operation is LW/LBU.
REQ-007 is_store_i  input  1  operation is SW/SB.
REQ-008 is_byte_i  input  1  byte (LBU/SB) rather than word.
REQ-009 addr_i  input  ADDR_W  byte address.
REQ-010 store_data_i  input  32  store operand; SB uses bits [7:0].
REQ-011 stall_o  output  1  core must hold its operation and pipeline.
REQ-012 done_o  output  1  one-cycle pulse: operation retired.
REQ-013 load_data_o  output  32  load result, valid while done_o is high for a load.
REQ-014 misaligned_o  output  1  one-cycle pulse: word access with addr_i[1:0]!=0, dropped.
REQ-015 mem_v_o  output  1  request valid to data memory.
REQ-016 mem_w_o  output  1  request is a write.
REQ-017 mem_addr_o  output  ADDR_W  word-aligned address, bits [1:0]=0.
REQ-018 mem_data_o  output  32  write data, byte replicated to all lanes for SB.
REQ-019 mem_mask_o  output  4  write byte enables.
REQ-020 mem_yumi_i  input  1  memory accepts request this cycle.
REQ-021 mem_v_i  input  1  read response valid.
REQ-022 mem_data_i  input  32  read response word.

Function
REQ-023 The FSM SHALL have states IDLE, REQ, RESP, DONE.
REQ-024 IDLE: valid_i with exactly one of is_load_i/is_store_i and an aligned address SHALL capture op, byte flag, addr, data, and go to REQ next cycle.
REQ-025 valid_i with both or neither of is_load_i/is_store_i SHALL be ignored.
REQ-026 A misaligned word access SHALL pulse misaligned_o the following cycle, issue no memory request, and remain in IDLE.
REQ-027 stall_o SHALL be high in REQ and RESP, and combinationally high in IDLE during an accepting cycle; low in DONE and IDLE otherwise.
REQ-028 REQ: mem_v_o SHALL be high, with address, write flag, data and mask held stable until mem_yumi_i.
REQ-029 Store, SW: mask 4'b1111; SB: mask one-hot at addr[1:0], data = {4{byte}}.
REQ-030 Store with mem_yumi_i SHALL go to DONE; load with mem_yumi_i SHALL go to RESP.
REQ-031 Load with mem_yumi_i and mem_v_i in the same cycle SHALL go directly to DONE, capturing mem_data_i.
REQ-032 RESP: mem_v_i SHALL capture the result and go to DONE; it SHALL wait indefinitely otherwise.
REQ-033 LW result = mem_data_i; LBU result = byte lane addr[1:0] zero-extended to 32 bits.
REQ-034 DONE SHALL assert done_o for exactly one cycle, then return to IDLE, and SHALL NOT accept a new operation that cycle.
REQ-035 mem_v_i outside REQ/RESP SHALL be ignored.
REQ-036 Minimum latency: store 2 cycles accept-to-done_o; load 2 cycles with same-cycle response.
REQ-037 Accept-to-accept throughput SHALL be at most one operation every three cycles.

Reset
REQ-038 When n_reset is low at an edge, the FSM SHALL enter IDLE, even mid-operation; any outstanding request is abandoned.
REQ-039 Reset values: stall_o, done_o, misaligned_o, mem_v_o, mem_w_o = 0; load_data_o, mem_addr_o, mem_data_o, mem_mask_o = 0.

Structure
REQ-040 The state enum and the mask constants SHALL live in the shared definitions package beside instruction_s.
REQ-041 Lane extraction and mask generation SHALL be one combinational sub-module, dmem_lane_align.

Verification
REQ-042 SW addr 0x100, data 0xDEADBEEF, yumi after 2 cycles -> mem_addr_o 0x100, mask 1111, done_o 1 cycle after yumi.
REQ-043 SB addr 0x103, data 0x5A -> mask 1000, mem_data_o 0x5A5A5A5A.
REQ-044 LBU addr 0x202, mem_data_i 0x11223344 -> load_data_o 0x00000022 with done_o.
REQ-045 LW addr 0x006 -> misaligned_o pulse, no mem_v_o, stall_o low afterwards.
REQ-046 LW, yumi and mem_v_i same cycle, data 0xCAFEF00D -> done_o the next cycle, load_data_o 0xCAFEF00D.
REQ-047 n_reset low during RESP -> IDLE next cycle, all outputs 0; late mem_v_i ignored.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and its lane aligner.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package dmem_responder_pkg;

    // Data path is one 32-bit word made of four byte lanes.
    localparam int WORD_W = 32;

    // Operation sequencing states of the responder.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } dmem_state_e;

    // Byte-enable patterns for the memory write port.
    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_B0   = 4'b0001;
    localparam logic [3:0] MASK_B1   = 4'b0010;
    localparam logic [3:0] MASK_B2   = 4'b0100;
    localparam logic [3:0] MASK_B3   = 4'b1000;

    // Captured memory instruction. The full address is held separately,
    // because its width is a parameter of the top level.
    typedef struct packed {
        logic       is_store;
        logic       is_byte;
        logic [1:0] lane;
    } instruction_s;

    // One-hot byte enable for a single-byte store at the given lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        logic [3:0] m;
        case (lane)
            2'd0:    m = MASK_B0;
            2'd1:    m = MASK_B1;
            2'd2:    m = MASK_B2;
            default: m = MASK_B3;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/data replication and load lane extraction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]        lane,
    input  logic              is_byte,
    input  logic [WORD_W-1:0] store_data,
    input  logic [WORD_W-1:0] load_word,
    output logic [3:0]        wr_mask,
    output logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] rd_data
);

    // Word accesses pass straight through; byte accesses pick or replicate one lane.
    always_comb begin
        wr_mask = MASK_WORD;
        wr_data = store_data;
        rd_data = load_word;
        if (is_byte) begin
            wr_mask = lane_mask(lane);
            wr_data = {4{store_data[7:0]}};
            rd_data = {24'd0, load_word[{lane, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Sequences one core load/store at a time onto a valid/yumi data-memory port.
// Latency: accept to done_o is 2 cycles minimum; at most one accept every 3 cycles.
// Backpressure: stall_o holds the core while a request or response is outstanding.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              valid_i,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic              is_byte_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              misaligned_o,
    output logic              mem_v_o,
    output logic              mem_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [3:0]        mem_mask_o,
    input  logic              mem_yumi_i,
    input  logic              mem_v_i,
    input  logic [DATA_W-1:0] mem_data_i
);

    dmem_state_e  state;
    instruction_s op_q;
    logic         stall_q;

    logic         op_ok;
    logic         aligned;
    logic         accept;
    logic         misalign;

    logic [1:0]        al_lane;
    logic              al_byte;
    logic [3:0]        al_mask;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;

    // Classify the incoming operation; only IDLE may accept or flag misalignment.
    always_comb begin
        op_ok    = valid_i & (is_load_i ^ is_store_i);
        aligned  = is_byte_i | (addr_i[1:0] == 2'b00);
        accept   = n_reset & (state == S_IDLE) & op_ok & aligned;
        misalign = n_reset & (state == S_IDLE) & op_ok & ~aligned;
    end

    // The accepting cycle must stall combinationally so the core holds its pipeline
    // until the registered stall takes over.
    assign stall_o = stall_q | accept;

    // In IDLE the aligner works on the incoming store; otherwise on the captured load.
    always_comb begin
        al_lane = op_q.lane;
        al_byte = op_q.is_byte;
        if (state == S_IDLE) begin
            al_lane = addr_i[1:0];
            al_byte = is_byte_i;
        end
    end

    dmem_lane_align u_lane_align (
        .lane       (al_lane),
        .is_byte    (al_byte),
        .store_data (store_data_i),
        .load_word  (mem_data_i),
        .wr_mask    (al_mask),
        .wr_data    (al_wdata),
        .rd_data    (al_rdata)
    );

    // Main sequencer: all handshake and result outputs are registered here.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            op_q         <= '0;
            stall_q      <= 1'b0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            load_data_o  <= '0;
            mem_v_o      <= 1'b0;
            mem_w_o      <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            mem_mask_o   <= '0;
        end else begin
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q.is_store <= is_store_i;
                        op_q.is_byte  <= is_byte_i;
                        op_q.lane     <= addr_i[1:0];
                        mem_addr_o    <= {addr_i[ADDR_W-1:2], 2'b00};
                        mem_w_o       <= is_store_i;
                        mem_data_o    <= is_store_i ? al_wdata : '0;
                        mem_mask_o    <= is_store_i ? al_mask : 4'b0000;
                        mem_v_o       <= 1'b1;
                        stall_q       <= 1'b1;
                        state         <= S_REQ;
                    end else if (misalign) begin
                        misaligned_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_yumi_i) begin
                        mem_v_o <= 1'b0;
                        if (op_q.is_store) begin
                            stall_q <= 1'b0;
                            done_o  <= 1'b1;
                            state   <= S_DONE;
                        end else if (mem_v_i) begin
                            load_data_o <= al_rdata;
                            stall_q     <= 1'b0;
                            done_o      <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_v_i) begin
                        load_data_o <= al_rdata;
                        stall_q     <= 1'b0;
                        done_o      <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: begin
                    // DONE: the retire pulse is out; refuse new work for this cycle.
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        valid_i, is_load_i, is_store_i, is_byte_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, done_o, misaligned_o;
    logic [31:0] load_data_o;
    logic        mem_v_o, mem_w_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_mask_o;
    logic        mem_yumi_i, mem_v_i;
    logic [31:0] mem_data_i;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .valid_i      (valid_i),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .is_byte_i    (is_byte_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .load_data_o  (load_data_o),
        .misaligned_o (misaligned_o),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_mask_o   (mem_mask_o),
        .mem_yumi_i   (mem_yumi_i),
        .mem_v_i      (mem_v_i),
        .mem_data_i   (mem_data_i)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // An operation is either absent, waiting for the memory to take it, or
    // waiting for read data. Completion yields a retire pulse the next cycle,
    // during which nothing new is taken.
    bit          m_live = 0;     // model has seen a reset edge
    bit          m_busy = 0;
    bit          m_taken = 0;    // memory has accepted the request
    bit          m_done = 0;
    bit          m_mis = 0;
    bit          m_rst = 0;      // previous edge was a reset edge
    bit          m_store, m_byte, m_done_load;
    logic [31:0] m_addr, m_data, m_load;

    function automatic logic [31:0] pick_load(input bit byt, input logic [1:0] lane,
                                              input logic [31:0] w);
        if (byt) return (w >> (8 * lane)) & 32'hFF;
        return w;
    endfunction

    always begin
        bit          acc, exp_v;
        logic [31:0] exp_mask, exp_wdata;
        @(negedge clk);
        #1;
        if (m_live) begin
            acc = n_reset && !m_busy && !m_done && valid_i && (is_load_i != is_store_i)
                  && (is_byte_i || addr_i[1:0] == 2'b00);
            exp_v = m_busy && !m_taken;
            chk("stall", {31'd0, stall_o}, {31'd0, m_busy || acc});
            chk("done", {31'd0, done_o}, {31'd0, m_done});
            chk("misaligned", {31'd0, misaligned_o}, {31'd0, m_mis});
            chk("mem_v", {31'd0, mem_v_o}, {31'd0, exp_v});
            if (m_done && m_done_load) chk("load_data", load_data_o, m_load);
            if (exp_v) begin
                chk("mem_addr", mem_addr_o, m_addr & ~32'h3);
                chk("mem_w", {31'd0, mem_w_o}, {31'd0, m_store});
                if (m_store) begin
                    exp_mask  = m_byte ? (32'h1 << m_addr[1:0]) : 32'hF;
                    exp_wdata = m_byte ? {4{m_data[7:0]}} : m_data;
                    chk("mem_mask", {28'd0, mem_mask_o}, exp_mask);
                    chk("mem_data", mem_data_o, exp_wdata);
                end
            end
            if (m_rst) begin
                chk("rst_load_data", load_data_o, 32'h0);
                chk("rst_mem_addr", mem_addr_o, 32'h0);
                chk("rst_mem_data", mem_data_o, 32'h0);
                chk("rst_mem_mask", {28'd0, mem_mask_o}, 32'h0);
                chk("rst_mem_w", {31'd0, mem_w_o}, 32'h0);
            end
        end
        @(posedge clk);
        if (!n_reset) begin
            m_live = 1; m_busy = 0; m_taken = 0; m_done = 0; m_mis = 0; m_rst = 1;
        end else if (m_live) begin
            bit fin, mis;
            fin = 0; mis = 0; m_rst = 0;
            if (m_busy) begin
                if (!m_taken) begin
                    if (mem_yumi_i) begin
                        if (m_store || mem_v_i) fin = 1;
                        else m_taken = 1;
                    end
                end else if (mem_v_i) begin
                    fin = 1;
                end
                if (fin) begin
                    m_busy = 0;
                    m_done_load = !m_store;
                    if (!m_store) m_load = pick_load(m_byte, m_addr[1:0], mem_data_i);
                end
            end else if (!m_done && valid_i && (is_load_i != is_store_i)) begin
                if (is_byte_i || addr_i[1:0] == 2'b00) begin
                    m_busy = 1; m_taken = 0;
                    m_store = is_store_i; m_byte = is_byte_i;
                    m_addr = addr_i; m_data = store_data_i;
                end else begin
                    mis = 1;
                end
            end
            m_done = fin;
            m_mis  = mis;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        valid_i = 0; is_load_i = 0; is_store_i = 0; is_byte_i = 0;
        mem_yumi_i = 0; mem_v_i = 0;
    endtask

    task automatic op(input bit ld, input bit byt, input logic [31:0] a, input logic [31:0] d);
        valid_i = 1; is_load_i = ld; is_store_i = !ld; is_byte_i = byt;
        addr_i = a; store_data_i = d;
    endtask

    initial begin
        n_reset = 0; idle_in();
        addr_i = 0; store_data_i = 0; mem_data_i = 0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_stall", {31'd0, stall_o}, 32'h0);
        chk("reset_done", {31'd0, done_o}, 32'h0);
        chk("reset_mem_v", {31'd0, mem_v_o}, 32'h0);
        chk("reset_misaligned", {31'd0, misaligned_o}, 32'h0);
        @(negedge clk); n_reset = 1;

        // SW 0x100, memory takes it after two waiting cycles
        @(negedge clk); op(0, 0, 32'h100, 32'hDEADBEEF);
        #2 chk("sw_accept_stall", {31'd0, stall_o}, 32'h1);
        @(negedge clk); idle_in();
        #2 chk("sw_mem_v", {31'd0, mem_v_o}, 32'h1);
        chk("sw_addr", mem_addr_o, 32'h100);
        chk("sw_mask", {28'd0, mem_mask_o}, 32'hF);
        chk("sw_data", mem_data_o, 32'hDEADBEEF);
        chk("sw_w", {31'd0, mem_w_o}, 32'h1);
        @(negedge clk);
        #2 chk("sw_addr_held", mem_addr_o, 32'h100);
        @(negedge clk); mem_yumi_i = 1;
        #2 chk("sw_no_early_done", {31'd0, done_o}, 32'h0);
        @(negedge clk); mem_yumi_i = 0; op(0, 0, 32'h104, 32'h1);
        #2 chk("sw_done", {31'd0, done_o}, 32'h1);
        chk("done_cycle_no_stall", {31'd0, stall_o}, 32'h0);
        @(negedge clk); idle_in();
        #2 chk("sw_done_one_cycle", {31'd0, done_o}, 32'h0);
        chk("done_cycle_not_accepted", {31'd0, mem_v_o}, 32'h0);

        // SB 0x103
        @(negedge clk); op(0, 1, 32'h103, 32'h1234565A);
        @(negedge clk); idle_in(); mem_yumi_i = 1;
        #2 chk("sb_mask", {28'd0, mem_mask_o}, 32'h8);
        chk("sb_data", mem_data_o, 32'h5A5A5A5A);
        @(negedge clk); idle_in();
        #2 chk("sb_done", {31'd0, done_o}, 32'h1);

        // LBU 0x202, response one cycle after acceptance
        @(negedge clk); idle_in();
        @(negedge clk); op(1, 1, 32'h202, 32'h0);
        @(negedge clk); idle_in(); mem_yumi_i = 1;
        #2 chk("lbu_addr", mem_addr_o, 32'h200);
        chk("lbu_w", {31'd0, mem_w_o}, 32'h0);
        @(negedge clk); mem_yumi_i = 0; mem_v_i = 1; mem_data_i = 32'h11223344;
        #2 chk("lbu_resp_stall", {31'd0, stall_o}, 32'h1);
        @(negedge clk); idle_in();
        #2 chk("lbu_done", {31'd0, done_o}, 32'h1);
        chk("lbu_data", load_data_o, 32'h00000022);

        // LW 0x006, misaligned
        @(negedge clk); idle_in();
        @(negedge clk); op(1, 0, 32'h006, 32'h0);
        #2 chk("mis_no_stall", {31'd0, stall_o}, 32'h0);
        @(negedge clk); idle_in();
        #2 chk("mis_pulse", {31'd0, misaligned_o}, 32'h1);
        chk("mis_no_req", {31'd0, mem_v_o}, 32'h0);
        @(negedge clk);
        #2 chk("mis_pulse_end", {31'd0, misaligned_o}, 32'h0);
        chk("mis_stall_low", {31'd0, stall_o}, 32'h0);

        // LW with same-cycle grant and response
        @(negedge clk); op(1, 0, 32'h400, 32'h0);
        @(negedge clk); idle_in(); mem_yumi_i = 1; mem_v_i = 1; mem_data_i = 32'hCAFEF00D;
        @(negedge clk); idle_in();
        #2 chk("lw_fast_done", {31'd0, done_o}, 32'h1);
        chk("lw_fast_data", load_data_o, 32'hCAFEF00D);

        // Reset while waiting for a read response
        @(negedge clk); idle_in();
        @(negedge clk); op(1, 0, 32'h500, 32'h0);
        @(negedge clk); idle_in(); mem_yumi_i = 1;
        @(negedge clk); idle_in(); n_reset = 0;
        @(negedge clk); n_reset = 1; mem_v_i = 1; mem_data_i = 32'h99999999;
        #2 chk("rst_mid_stall", {31'd0, stall_o}, 32'h0);
        chk("rst_mid_mem_v", {31'd0, mem_v_o}, 32'h0);
        chk("rst_mid_load_data", load_data_o, 32'h0);
        @(negedge clk); idle_in();
        #2 chk("late_resp_ignored", {31'd0, done_o}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_reset      = ($urandom_range(0, 80) != 0);
            valid_i      = $urandom_range(0, 1);
            is_load_i    = $urandom_range(0, 1);
            is_store_i   = $urandom_range(0, 1);
            is_byte_i    = $urandom_range(0, 1);
            addr_i       = $urandom;
            store_data_i = $urandom;
            mem_yumi_i   = $urandom_range(0, 1);
            mem_v_i      = ($urandom_range(0, 2) == 0);
            mem_data_i   = $urandom;
        end
        @(negedge clk); idle_in(); n_reset = 1;
        repeat (2) @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
